// File: rtl/template_pulse_injector_if.sv
// Bus bundle for template_pulse_injector: SSR sample blocks, trigger controls and status.
// pol_i exists only when INJECT_POLARITY_EN is defined.
interface template_pulse_injector_if #(
  parameter int NBITS  = 12,
  parameter int NSAMPS = 8
);
  logic [NBITS*NSAMPS-1:0] data_i;
  logic                    trig_i;
  logic [2:0]              trig_phase_i;
  logic [1:0]              trig_scale_i;
`ifdef INJECT_POLARITY_EN
  logic                    pol_i;
`endif
  logic [NBITS*NSAMPS-1:0] data_o;
  logic                    busy_o;
  logic                    done_o;

  modport master (
`ifdef INJECT_POLARITY_EN
    output pol_i,
`endif
    output data_i, trig_i, trig_phase_i, trig_scale_i,
    input  data_o, busy_o, done_o
  );

  modport slave (
`ifdef INJECT_POLARITY_EN
    input  pol_i,
`endif
    input  data_i, trig_i, trig_phase_i, trig_scale_i,
    output data_o, busy_o, done_o
  );
endinterface

// File: rtl/template_pulse_injector.sv
// Adds the time-reversed matched-filter kernel into an 8-lane SSR ADC stream on a trigger,
// scaled by 2^scale and saturated. Optional feature macro: INJECT_POLARITY_EN (adds pol_i).
module template_pulse_injector #(
  parameter int NBITS  = 12,
  parameter int NSAMPS = 8,
  parameter int TLEN   = 42
) (
  input logic                     aclk,
  input logic                     rst,
  template_pulse_injector_if.slave bus
);
  localparam int         W        = NBITS * NSAMPS;
  localparam logic [2:0] LAST_BLK = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     blk_q, blk_d;
  logic [2:0]     phase_q, phase_d;
  logic [1:0]     scale_q, scale_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           armed_q;
  logic [W-1:0]   data_q, data_d;
`ifdef INJECT_POLARITY_EN
  logic           pol_q, pol_d;
`endif

  // Template s[n] = h_z[41-n], stored as 4-bit signed coefficients.
  function automatic logic [3:0] tmpl_coef(input logic [5:0] idx);
    case (idx)
      6'd0, 6'd1, 6'd4, 6'd6, 6'd17, 6'd21, 6'd23, 6'd26,
      6'd27, 6'd32, 6'd33, 6'd37:                              tmpl_coef = 4'sd1;
      6'd2, 6'd15, 6'd18, 6'd20, 6'd24, 6'd25, 6'd29, 6'd30,
      6'd35, 6'd41:                                            tmpl_coef = -4'sd1;
      6'd11, 6'd16, 6'd22:                                     tmpl_coef = 4'sd2;
      6'd3, 6'd13, 6'd14, 6'd19:                               tmpl_coef = -4'sd2;
      6'd5, 6'd10:                                             tmpl_coef = 4'sd4;
      6'd7, 6'd8:                                              tmpl_coef = -4'sd4;
      default:                                                 tmpl_coef = 4'sd0;
    endcase
  endfunction

  function automatic logic [NBITS-1:0] sat(input logic [NBITS:0] v);
    if (v[NBITS] != v[NBITS-1]) begin
      sat = v[NBITS] ? {1'b1, {(NBITS-1){1'b0}}} : {1'b0, {(NBITS-1){1'b1}}};
    end else begin
      sat = v[NBITS-1:0];
    end
  endfunction

  // Next-state and control decode
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    phase_d = phase_q;
    scale_d = scale_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef INJECT_POLARITY_EN
    pol_d   = pol_q;
`endif
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        // armed_q is low for the first edge after reset release so that trigger is dropped.
        if (bus.trig_i && armed_q) begin
          state_d = ST_PLAY;
          blk_d   = 3'd0;
          phase_d = bus.trig_phase_i;
          scale_d = bus.trig_scale_i;
          busy_d  = 1'b1;
`ifdef INJECT_POLARITY_EN
          pol_d   = bus.pol_i;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (blk_q == LAST_BLK) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          blk_d  = blk_q + 3'd1;
          busy_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        blk_d   = 3'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Per-lane template add with saturation
  always_comb begin
    logic [6:0]       n;
    logic             hit;
    logic [3:0]       c;
    logic [6:0]       t;
    logic [NBITS-1:0] lane;
    logic [NBITS:0]   sum;
    data_d = '0;
    n      = 7'd0;
    hit    = 1'b0;
    c      = 4'd0;
    t      = 7'd0;
    lane   = '0;
    sum    = '0;
    for (int i = 0; i < NSAMPS; i++) begin
      lane = bus.data_i[NBITS*i +: NBITS];
      // Modular 7-bit index: bit 6 set means the lane precedes s[0].
      n    = {1'b0, blk_q, 3'b000} + 7'(i) - {4'b0000, phase_q};
      hit  = (state_q == ST_PLAY) && !n[6] && (n[5:0] < 6'(TLEN));
      c    = hit ? tmpl_coef(n[5:0]) : 4'd0;
      t    = {{3{c[3]}}, c} << scale_q;
`ifdef INJECT_POLARITY_EN
      if (pol_q) begin
        t = 7'd0 - t;
      end else begin
        t = t;
      end
`endif
      sum  = {lane[NBITS-1], lane} + {{(NBITS-6){t[6]}}, t};
      data_d[NBITS*i +: NBITS] = sat(sum);
    end
  end

  // Control state registers
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      blk_q   <= 3'd0;
      phase_q <= 3'd0;
      scale_q <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
`ifdef INJECT_POLARITY_EN
      pol_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
      scale_q <= scale_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      armed_q <= 1'b1;
`ifdef INJECT_POLARITY_EN
      pol_q   <= pol_d;
`endif
    end
  end

  // Output sample register
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign bus.data_o = data_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
endmodule

// File: tb/tb_template_pulse_injector.sv
// Scoreboard bench for template_pulse_injector; expected blocks come from a cycle-age model.
module tb_template_pulse_injector;
  localparam int TMPL [0:41] = '{
     1,  1, -1, -2,  1,  4,  1, -4, -4,  0,  4,  2,  0, -2, -2, -1,
     2,  1, -1, -2, -1,  1,  2,  1, -1, -1,  1,  1,  0, -1, -1,  0,
     1,  1,  0, -1,  0,  1,  0,  0,  0, -1};

  typedef struct {
    logic [95:0] data;
    logic        busy;
    logic        done;
  } exp_t;

  logic aclk = 1'b0;
  logic rst  = 1'b1;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_age = 0, m_phase = 0, m_scale = 0;
  bit   m_neg = 1'b0, m_armed = 1'b0;

  template_pulse_injector_if #(.NBITS(12), .NSAMPS(8)) bus ();
  template_pulse_injector dut (.aclk(aclk), .rst(rst), .bus(bus));

  always #5 aclk = ~aclk;

  function automatic int lane(input logic [95:0] d, input int i);
    int v;
    v = $signed(d[12*i +: 12]);
    return v;
  endfunction

  // age 1..7 = playing block age-1, 8 = done cycle, 0 = idle
  function automatic logic [95:0] model_block(input logic [95:0] din, input int age,
                                              input int ph, input int sc, input bit neg);
    logic [95:0] r;
    int v, n, t;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      v = $signed(din[12*i +: 12]);
      if (age >= 1 && age <= 7) begin
        n = 8 * (age - 1) + i - ph;
        if (n >= 0 && n < 42) begin
          t = TMPL[n] * (1 << sc);
          v = neg ? v - t : v + t;
        end
      end
      if (v > 2047) v = 2047;
      if (v < -2048) v = -2048;
      r[12*i +: 12] = v[11:0];
    end
    return r;
  endfunction

  task automatic drive_cycle(input logic [95:0] din, input bit trig, input int ph,
                             input int sc, input bit neg);
    exp_t e;
    @(negedge aclk);
    bus.data_i       = din;
    bus.trig_i       = trig;
    bus.trig_phase_i = 3'(ph);
    bus.trig_scale_i = 2'(sc);
`ifdef INJECT_POLARITY_EN
    bus.pol_i        = neg;
`endif
    e.data = model_block(din, m_age, m_phase, m_scale, m_neg);
    if (m_age >= 1 && m_age <= 7) m_age++;
    else if (m_age == 8) m_age = 0;
    else if (trig && m_armed) begin
      m_age = 1; m_phase = ph; m_scale = sc; m_neg = neg;
    end
    m_armed = 1'b1;
    e.busy = (m_age >= 1 && m_age <= 7);
    e.done = (m_age == 8);
    exp_q.push_back(e);
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [95:0] fill(input int v);
    logic [95:0] r;
    for (int i = 0; i < 8; i++) r[12*i +: 12] = 12'(v);
    return r;
  endfunction

  task automatic test_reset();
    exp_t e;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (bus.data_o !== 96'd0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: data_o=%h busy=%b done=%b expected all zero",
               bus.data_o, bus.busy_o, bus.done_o);
    end
    rst = 1'b0;
    // trigger in the release cycle must be dropped
    for (int k = 0; k < 3; k++) begin
      drive_cycle(fill(k + 5), k == 0, 0, 0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (bus.data_o !== e.data || bus.busy_o !== e.busy || bus.done_o !== e.done) begin
        errors++;
        $display("FAIL reset_release cyc%0d: data_o=%h busy=%b done=%b expected %h %b %b",
                 k, bus.data_o, bus.busy_o, bus.done_o, e.data, e.busy, e.done);
      end
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int   dones = 0;
    int   lit0 [8] = '{1, 1, -1, -2, 1, 4, 1, -4};
    int   lit1 [8] = '{-4, 0, 4, 2, 0, -2, -2, -1};
    for (int k = 0; k < 10; k++) begin
      drive_cycle(96'd0, k == 0, 0, 0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (bus.data_o !== e.data || bus.busy_o !== e.busy || bus.done_o !== e.done) begin
        errors++;
        $display("FAIL basic cyc%0d: data_o=%h busy=%b done=%b expected %h %b %b",
                 k, bus.data_o, bus.busy_o, bus.done_o, e.data, e.busy, e.done);
      end
      if (bus.done_o === 1'b1) dones++;
      for (int i = 0; i < 8; i++) begin
        if (k == 1 || k == 2) begin
          checks++;
          if (lane(bus.data_o, i) != (k == 1 ? lit0[i] : lit1[i])) begin
            errors++;
            $display("FAIL basic_block%0d lane%0d: got %0d expected %0d", k, i,
                     lane(bus.data_o, i), k == 1 ? lit0[i] : lit1[i]);
          end
        end
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL basic_done_count: got %0d expected 1", dones);
    end
  endtask

  task automatic test_phase7();
    exp_t e;
    for (int k = 0; k < 10; k++) begin
      drive_cycle(96'd0, k == 0, 7, 0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (bus.data_o !== e.data || bus.busy_o !== e.busy || bus.done_o !== e.done) begin
        errors++;
        $display("FAIL phase7 cyc%0d: data_o=%h busy=%b done=%b expected %h %b %b",
                 k, bus.data_o, bus.busy_o, bus.done_o, e.data, e.busy, e.done);
      end
      if (k == 1 || k == 7) begin
        checks++;
        if (bus.data_o !== (k == 1 ? {12'd1, 84'd0} : {84'd0, 12'hFFF})) begin
          errors++;
          $display("FAIL phase7_edge_block%0d: got %h", k, bus.data_o);
        end
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 10; k++) begin
        drive_cycle(fill(r == 0 ? 2047 : -2048), k == 0, 0, 3, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (bus.data_o !== e.data || bus.busy_o !== e.busy || bus.done_o !== e.done) begin
          errors++;
          $display("FAIL sat%0d cyc%0d: data_o=%h busy=%b done=%b expected %h %b %b",
                   r, k, bus.data_o, bus.busy_o, bus.done_o, e.data, e.busy, e.done);
        end
        if (k == 1 && r == 0) begin
          checks++;
          if (lane(bus.data_o, 5) != 2047 || lane(bus.data_o, 7) != 2015 ||
              lane(bus.data_o, 2) != 2039) begin
            errors++;
            $display("FAIL sat_pos: lane5=%0d lane7=%0d lane2=%0d expected 2047 2015 2039",
                     lane(bus.data_o, 5), lane(bus.data_o, 7), lane(bus.data_o, 2));
          end
        end
        if (k == 1 && r == 1) begin
          checks++;
          if (lane(bus.data_o, 7) != -2048) begin
            errors++;
            $display("FAIL sat_neg: lane7=%0d expected -2048", lane(bus.data_o, 7));
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   dones = 0;
    for (int k = 0; k < 20; k++) begin
      drive_cycle(96'd0, (k == 0 || k == 3 || k == 8 || k == 9), 0, 0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (bus.data_o !== e.data || bus.busy_o !== e.busy || bus.done_o !== e.done) begin
        errors++;
        $display("FAIL b2b cyc%0d: data_o=%h busy=%b done=%b expected %h %b %b",
                 k, bus.data_o, bus.busy_o, bus.done_o, e.data, e.busy, e.done);
      end
      if (bus.done_o === 1'b1) dones++;
    end
    checks++;
    if (dones != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d expected 2", dones);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   dones = 0;
    for (int k = 0; k < 3; k++) begin
      drive_cycle({$urandom, $urandom, $urandom} | 96'd1, k == 0, 0, 2, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (bus.data_o !== e.data || bus.busy_o !== e.busy) begin
        errors++;
        $display("FAIL abort_pre cyc%0d: data_o=%h busy=%b expected %h %b",
                 k, bus.data_o, bus.busy_o, e.data, e.busy);
      end
    end
    @(negedge aclk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.data_o !== 96'd0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: data_o=%h busy=%b done=%b expected all zero",
               bus.data_o, bus.busy_o, bus.done_o);
    end
    m_age = 0;
    m_armed = 1'b0;
    @(posedge aclk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive_cycle({$urandom, $urandom, $urandom}, k == 0, 0, 0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (bus.data_o !== e.data || bus.busy_o !== e.busy || bus.done_o !== e.done) begin
        errors++;
        $display("FAIL abort_post cyc%0d: data_o=%h busy=%b done=%b expected %h %b %b",
                 k, bus.data_o, bus.busy_o, bus.done_o, e.data, e.busy, e.done);
      end
      if (bus.done_o === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_done_count: got %0d expected 0", dones);
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int k = 0; k < 60; k++) begin
      drive_cycle({$urandom, $urandom, $urandom}, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 3), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (bus.data_o !== e.data || bus.busy_o !== e.busy || bus.done_o !== e.done) begin
        errors++;
        $display("FAIL random cyc%0d: data_o=%h busy=%b done=%b expected %h %b %b",
                 k, bus.data_o, bus.busy_o, bus.done_o, e.data, e.busy, e.done);
      end
    end
    for (int k = 0; k < 10; k++) begin
      drive_cycle(96'd0, 1'b0, 0, 0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (bus.data_o !== e.data || bus.busy_o !== e.busy || bus.done_o !== e.done) begin
        errors++;
        $display("FAIL random_drain cyc%0d: data_o=%h busy=%b done=%b expected %h %b %b",
                 k, bus.data_o, bus.busy_o, bus.done_o, e.data, e.busy, e.done);
      end
    end
  endtask

`ifdef INJECT_POLARITY_EN
  task automatic test_polarity();
    exp_t e;
    int   lit [8] = '{-2, -2, 2, 4, -2, -8, -2, 8};
    for (int k = 0; k < 10; k++) begin
      drive_cycle(96'd0, k == 0, 0, 1, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (bus.data_o !== e.data || bus.busy_o !== e.busy || bus.done_o !== e.done) begin
        errors++;
        $display("FAIL polarity cyc%0d: data_o=%h busy=%b done=%b expected %h %b %b",
                 k, bus.data_o, bus.busy_o, bus.done_o, e.data, e.busy, e.done);
      end
      if (k == 1) begin
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (lane(bus.data_o, i) != lit[i]) begin
            errors++;
            $display("FAIL polarity_lane%0d: got %0d expected %0d", i,
                     lane(bus.data_o, i), lit[i]);
          end
        end
      end
    end
  endtask
`endif

  initial begin
    bus.data_i       = '0;
    bus.trig_i       = 1'b0;
    bus.trig_phase_i = 3'd0;
    bus.trig_scale_i = 2'd0;
`ifdef INJECT_POLARITY_EN
    bus.pol_i        = 1'b0;
`endif
    test_reset();
    test_basic();
    test_phase7();
    test_saturation();
    test_back_to_back();
    test_reset_abort();
    test_random();
`ifdef INJECT_POLARITY_EN
    test_polarity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
